// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and decode helpers for the nibble-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return is_addsub(op) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/nibble_slice.sv
// Combinational 4-bit AND/OR/add slice; exposes carry into and out of bit 3 for overflow.
module nibble_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic [3:0] sum,
    output logic       c3,
    output logic       c4
);

    logic [3:0] bx;
    logic [3:0] lo;
    logic [1:0] hi;

    always_comb begin
        bx  = op[2] ? ~b : b;
        // Split at bit 3 so the carry into the sign bit is visible.
        lo  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
        hi  = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
        sum = a & b;
        c3  = 1'b0;
        c4  = 1'b0;
        if (op == OP_OR) begin
            sum = a | b;
        end else if (is_arith(op)) begin
            sum = {hi[0], lo[2:0]};
            c3  = lo[3];
            c4  = hi[1];
        end
    end

endmodule

// File: rtl/nibble_serial_alu32.sv
// Multi-cycle ALU: one operation per NIB passes through a single 4-bit slice, LSB nibble first.
module nibble_serial_alu32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [3:0] s_sum;
    logic       s_c3, s_c4;

    nibble_slice u_slice (
        .a   (a_q[{idx_q, 2'b00} +: 4]),
        .b   (b_q[{idx_q, 2'b00} +: 4]),
        .cin (carry_q),
        .op  (op_q),
        .sum (s_sum),
        .c3  (s_c3),
        .c4  (s_c4)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)           state_d = ST_RUN;
            ST_RUN:  if (idx_q == LastIdx)   state_d = ST_DONE;
            ST_DONE: if (out_ready)          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == ST_IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            idx_d   = '0;
            carry_d = op[2];
        end else if (state_q == ST_RUN) begin
            result_d[{idx_q, 2'b00} +: 4] = s_sum;
            carry_d = s_c4;
            idx_d   = idx_q + IdxW'(1);
            if (idx_q == LastIdx) begin
                cout_d = is_addsub(op_q) & s_c4;
                ovf_d  = is_addsub(op_q) & (s_c3 ^ s_c4);
                // Signed less-than: sign of the difference corrected by overflow.
                if (op_q == OP_SLT) begin
                    result_d = {{(WIDTH-1){1'b0}}, s_sum[3] ^ s_c3 ^ s_c4};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = (result_q == '0);

endmodule

// File: tb/tb_nibble_serial_alu32.sv
// Scoreboard bench: driver pushes model results on acceptance, monitor pops on each output handshake.
module tb_nibble_serial_alu32;
    import alu_pkg::*;

    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, result;
    logic [2:0]  in_op;
    logic        cout, overflow, zero;

    nibble_serial_alu32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (in_a),
        .b         (in_b),
        .op        (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;
    logic rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the operation definitions.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t e;
        logic [32:0] s;
        e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.acc = 0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0]; e.cout = s[32];
                e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0]; e.cout = s[32];
                e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_OR:   e.res = a | b;
            default: e.res = a & b;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && sbq.size() > 0)
                check("latency", 32'(cyc - sbq[0].acc), NIB);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got result %h expected no output", result);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", result, mon_e.res);
                    check("cout", {31'd0, cout}, {31'd0, mon_e.cout});
                    check("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
                    check("zero", {31'd0, zero}, {31'd0, mon_e.zero});
                end
            end
            prev_ov = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output int acc);
        exp_t e;
        int t = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e = model(a, b, op);
        e.acc = cyc;
        sbq.push_back(e);
        // Scramble inputs: the block must only use its latched copies.
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0 || !in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners[6];
        corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h0000_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    logic [31:0] dir_a[10];
    logic [31:0] dir_b[10];
    logic [2:0]  dir_op[10];

    initial begin
        int acc, prev_acc, tmo;
        logic [2:0] ops[8];
        exp_t held;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, 3'b011, 3'b100, 3'b101};
        dir_a  = '{32'h0000_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001,
                   32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        dir_b  = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF,
                   32'h7FFF_FFFF, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
        dir_op = '{OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLT, OP_SLT, OP_AND, OP_OR, 3'b011, 3'b100};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cout_ovf", {30'd0, cout, overflow}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed, back-to-back with out_ready high: one op every NIB+2 cycles.
        prev_acc = 0;
        for (int i = 0; i < 10; i++) begin
            issue(dir_a[i], dir_b[i], dir_op[i], acc);
            if (i > 0) check("throughput", 32'(acc - prev_acc), NIB + 2);
            prev_acc = acc;
        end
        drain();

        // Stall in DONE for 5 cycles; in_valid pulses must be ignored.
        out_ready = 1'b0;
        issue(32'h8000_0000, 32'h0000_0001, OP_SUB, acc);
        held = model(32'h8000_0000, 32'h0000_0001, OP_SUB);
        tmo = 0;
        while (!out_valid && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_result", result, held.res);
            check("stall_flags", {29'd0, out_valid, cout, overflow}, {29'd0, 1'b1, held.cout, held.ovf});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = i[0];
            in_a = $urandom; in_b = $urandom; in_op = OP_ADD;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 check("release_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        drain();

        // Randomised ops with random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(rand_operand(), rand_operand(), ops[$urandom_range(0, 7)], acc);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        // Reset at RUN index 4 aborts the operation.
        issue(32'h1234_5678, 32'h1111_1111, OP_ADD, acc);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_flags", {29'd0, out_valid, cout, overflow}, 32'd0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        #1 check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(32'd1, 32'd1, OP_ADD, acc);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
